return_address_stack: RTL and testbench
=======================================

Name: return_address_stack

Overview:
- Circular return-address stack (RAS) for the fetch stage. It pushes the link address when a call (JAL/JALR writing x1/x5) executes and supplies the predicted target when a return (JALR reading x1/x5) executes.
- It is the consuming end of the jump-target path. The predicted target is checked one cycle later against the actual target computed by the jump-target logic, and a registered mispredict pulse is raised on mismatch.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH).
- XLEN, 32, address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- push_valid  input  1  call executed this cycle.
- push_addr  input  XLEN  link address (PC+4).
- pop_valid  input  1  return executed this cycle.
- flush  input  1  pipeline flush; empties the stack.
- top_valid  output  1  stack non-empty (combinational from state).
- top_addr  output  XLEN  current top entry (combinational); 0 when empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- resolve_valid  input  1  the return popped last cycle now has its actual target.
- resolve_target  input  XLEN  actual JALR target (rs1+imm, bit 0 cleared).
- mispredict  output  1  registered one-cycle pulse: predicted != actual.
- underflow  output  1  registered one-cycle pulse: pop while empty.

Behaviour:
- Reset (rst=1 at a clock edge): tos=0, count=0, all entries=0, mispredict=0, underflow=0, internal pred_reg=0, pred_valid=0. rst has priority over every other input.
- State: entry array [DEPTH], tos pointer (PTR_W bits) indexing the top entry, count.
- top_addr = entry[tos] when count>0, else 0. top_valid = (count!=0).
- Priority per edge: rst > flush > push/pop.
- Flush: count<=0. tos and entries are unchanged. pred_valid<=0. Pulses are not asserted.
- Push only:
  - tos<=tos+1 (mod DEPTH); entry[tos+1]<=push_addr.
  - count<=min(count+1, DEPTH).
  - When full, the oldest entry is silently overwritten (wrap-around); count stays DEPTH.
- Pop only, count>0:
  - pred_reg<=entry[tos]; pred_valid<=1.
  - tos<=tos-1 (mod DEPTH); count<=count-1.
- Pop only, count==0:
  - tos and count are unchanged.
  - underflow<=1 for one cycle.
  - pred_reg<=0; pred_valid<=1, so the following resolve compares against 0.
- Push and pop in the same cycle (return-and-call):
  - When count>0: pred_reg<=entry[tos]; pred_valid<=1; entry[tos]<=push_addr (top replaced). tos and count are unchanged.
  - When count==0: treat as pop-on-empty (underflow pulse, pred_reg<=0, pred_valid<=1), then push (tos+1, count=1).
- Latency: a push is visible on top_addr the next cycle. The prediction is captured at the pop edge and compared on the following edge.
- Resolve:
  - On an edge with resolve_valid=1 and pred_valid=1: mispredict<=(resolve_target!=pred_reg); pred_valid<=0 unless a new pop in the same cycle sets it again (the new pop wins).
  - resolve_valid with pred_valid=0 is ignored (mispredict<=0).
- Pulses: mispredict and underflow deassert the cycle after assertion unless re-triggered.
- Reset mid-operation: all state clears regardless of a pending resolve; no pulse is generated.
- Widths: count is PTR_W+1 bits so it can hold DEPTH. Pointer arithmetic wraps modulo DEPTH.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> count=3, top_addr=0x300. Pop -> top_addr=0x200. Resolve 0x300 next cycle -> mispredict=0.
- Push 0x104, pop, resolve_target=0x108 -> mispredict=1 for exactly one cycle, then 0.
- Push 0x10,0x20,...,0x90 (9 pushes, DEPTH=8) -> count=8, top_addr=0x90. Pop 8 times -> yields 0x90 down to 0x20. count=0, top_valid=0, top_addr=0.
- Pop on empty -> underflow=1 for one cycle, count=0. Resolve 0x0 -> mispredict=0; resolve 0x44 -> mispredict=1.
- With 0xA0 on top (count=2), assert push (0xB0) and pop together -> count=2, top_addr=0xB0. Resolve 0xA0 -> mispredict=0.
- Push 0x50, pop, then flush together with resolve_valid (target 0x99) on the next edge -> count=0, top_valid=0, mispredict stays 0. Separately, assert rst while stack is loaded -> count=0, top_addr=0, pulses=0.

Source files
------------

// File: rtl/return_address_stack_if.sv
// Return-address-stack bus: call/return events from the fetch stage,
// the top-of-stack prediction, and the resolve/mispredict path.
interface return_address_stack_if #(
    parameter int PTR_W = 3,
    parameter int XLEN  = 32
);
    logic             push_valid;
    logic [XLEN-1:0]  push_addr;
    logic             pop_valid;
    logic             flush;
    logic             top_valid;
    logic [XLEN-1:0]  top_addr;
    logic [PTR_W:0]   count;
    logic             resolve_valid;
    logic [XLEN-1:0]  resolve_target;
    logic             mispredict;
    logic             underflow;

    // Fetch/resolve side: drives events, observes prediction and pulses.
    modport master (
        output push_valid, push_addr, pop_valid, flush,
        output resolve_valid, resolve_target,
        input  top_valid, top_addr, count, mispredict, underflow
    );

    // Stack side.
    modport slave (
        input  push_valid, push_addr, pop_valid, flush,
        input  resolve_valid, resolve_target,
        output top_valid, top_addr, count, mispredict, underflow
    );
endinterface

// File: rtl/return_address_stack.sv
// Circular return-address stack. Calls push the link address, returns pop
// the predicted target; the prediction is held for one cycle and compared
// with the actual JALR target to raise a registered mispredict pulse.
// When full, pushes wrap and overwrite the oldest entry.
module return_address_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    return_address_stack_if.slave bus
);
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [XLEN-1:0]  ADDR_ZERO = {XLEN{1'b0}};

    logic [XLEN-1:0]  entry_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [XLEN-1:0]  pred_q, pred_d;
    logic             pred_valid_q, pred_valid_d;
    logic             mispredict_q, mispredict_d;
    logic             underflow_q, underflow_d;

    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic             empty_s;

    assign empty_s = (count_q == CNT_ZERO);

    // Next-state logic: flush beats push/pop; a pop in the same cycle as a
    // resolve re-arms the prediction after the old one has been compared.
    always_comb begin
        tos_d        = tos_q;
        count_d      = count_q;
        pred_d       = pred_q;
        pred_valid_d = pred_valid_q;
        mispredict_d = 1'b0;
        underflow_d  = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = tos_q;

        if (bus.flush) begin
            count_d      = CNT_ZERO;
            pred_valid_d = 1'b0;
        end else begin
            if (bus.resolve_valid && pred_valid_q) begin
                mispredict_d = (bus.resolve_target != pred_q);
                pred_valid_d = 1'b0;
            end else begin
                mispredict_d = 1'b0;
            end

            if (bus.pop_valid) begin
                pred_valid_d = 1'b1;
                if (!empty_s) begin
                    pred_d = entry_q[tos_q];
                    if (bus.push_valid) begin
                        // Return-and-call: replace the top in place.
                        wr_en_s  = 1'b1;
                        wr_idx_s = tos_q;
                    end else begin
                        tos_d   = tos_q - PTR_ONE;
                        count_d = count_q - CNT_ONE;
                    end
                end else begin
                    // Pop on empty predicts 0 and flags underflow.
                    pred_d      = ADDR_ZERO;
                    underflow_d = 1'b1;
                    if (bus.push_valid) begin
                        tos_d    = tos_q + PTR_ONE;
                        wr_en_s  = 1'b1;
                        wr_idx_s = tos_q + PTR_ONE;
                        count_d  = CNT_ONE;
                    end else begin
                        tos_d   = tos_q;
                        count_d = count_q;
                    end
                end
            end else if (bus.push_valid) begin
                tos_d    = tos_q + PTR_ONE;
                wr_en_s  = 1'b1;
                wr_idx_s = tos_q + PTR_ONE;
                count_d  = (count_q == CNT_FULL) ? CNT_FULL : (count_q + CNT_ONE);
            end else begin
                tos_d   = tos_q;
                count_d = count_q;
            end
        end
    end

    // Control and prediction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q        <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            pred_q       <= ADDR_ZERO;
            pred_valid_q <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            tos_q        <= tos_d;
            count_q      <= count_d;
            pred_q       <= pred_d;
            pred_valid_q <= pred_valid_d;
            mispredict_q <= mispredict_d;
            underflow_q  <= underflow_d;
        end
    end

    // Entry storage; a single write port serves both push and top-replace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= ADDR_ZERO;
            end
        end else if (wr_en_s) begin
            entry_q[wr_idx_s] <= bus.push_addr;
        end
    end

    assign bus.top_valid  = !empty_s;
    assign bus.top_addr   = empty_s ? ADDR_ZERO : entry_q[tos_q];
    assign bus.count      = count_q;
    assign bus.mispredict = mispredict_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_return_address_stack.sv
// Directed, table-driven bench for return_address_stack (DEPTH=8, XLEN=32).
module tb_return_address_stack;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    return_address_stack_if #(.PTR_W(3), .XLEN(32)) bus ();

    return_address_stack #(.DEPTH(8), .PTR_W(3), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        push;
        logic [31:0] paddr;
        logic        pop;
        logic        flush;
        logic        res;
        logic [31:0] rtgt;
        logic [3:0]  e_cnt;
        logic [31:0] e_top;
        logic        e_mis;
        logic        e_und;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic pu, logic [31:0] pa, logic po, logic fl,
                                logic rs, logic [31:0] rt, logic [3:0] ec,
                                logic [31:0] et, logic em, logic eu);
        vec_t v;
        v.rst = r; v.push = pu; v.paddr = pa; v.pop = po; v.flush = fl;
        v.res = rs; v.rtgt = rt; v.e_cnt = ec; v.e_top = et; v.e_mis = em; v.e_und = eu;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        rst                = v.rst;
        bus.push_valid     = v.push;
        bus.push_addr      = v.paddr;
        bus.pop_valid      = v.pop;
        bus.flush          = v.flush;
        bus.resolve_valid  = v.res;
        bus.resolve_target = v.rtgt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(vec_t v, int idx);
        chk("count",      idx, 32'(bus.count),      32'(v.e_cnt));
        chk("top_valid",  idx, 32'(bus.top_valid),  32'(v.e_cnt != 4'd0));
        chk("top_addr",   idx, bus.top_addr,        v.e_top);
        chk("mispredict", idx, 32'(bus.mispredict), 32'(v.e_mis));
        chk("underflow",  idx, 32'(bus.underflow),  32'(v.e_und));
    endtask

    initial begin
        vec_t hv;
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.push_valid = 1'b0; bus.push_addr = 32'h0; bus.pop_valid = 1'b0;
        bus.flush = 1'b0; bus.resolve_valid = 1'b0; bus.resolve_target = 32'h0;

        //   rst   push  paddr         pop   flush res   rtgt          cnt   top           mis   und
        add(1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b0);
        // basic LIFO and correct prediction
        add(1'b0, 1'b1, 32'h100,     1'b0, 1'b0, 1'b0, 32'h0,       4'd1, 32'h100,     1'b0, 1'b0);
        add(1'b0, 1'b1, 32'h200,     1'b0, 1'b0, 1'b0, 32'h0,       4'd2, 32'h200,     1'b0, 1'b0);
        add(1'b0, 1'b1, 32'h300,     1'b0, 1'b0, 1'b0, 32'h0,       4'd3, 32'h300,     1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd2, 32'h200,     1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h300,     4'd2, 32'h200,     1'b0, 1'b0);
        // mispredict pulse for one cycle
        add(1'b0, 1'b1, 32'h104,     1'b0, 1'b0, 1'b0, 32'h0,       4'd3, 32'h104,     1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd2, 32'h200,     1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h108,     4'd2, 32'h200,     1'b1, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       4'd2, 32'h200,     1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b0);
        // nine pushes into eight entries: 0x10 is overwritten
        for (int i = 1; i <= 9; i++) begin
            add(1'b0, 1'b1, 32'(i * 16), 1'b0, 1'b0, 1'b0, 32'h0,
                (i > 8) ? 4'd8 : 4'(i), 32'(i * 16), 1'b0, 1'b0);
        end
        // eight pops, each resolving the previous pop's prediction
        for (int k = 1; k <= 8; k++) begin
            add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, (k > 1), 32'((11 - k) * 16),
                4'(8 - k), (k < 8) ? 32'((9 - k) * 16) : 32'h0, 1'b0, 1'b0);
        end
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h20,      4'd0, 32'h0,       1'b0, 1'b0);
        // pop on empty predicts zero
        add(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,       4'd0, 32'h0,       1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h44,      4'd0, 32'h0,       1'b1, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b0);
        // return-and-call replaces the top
        add(1'b0, 1'b1, 32'h70,      1'b0, 1'b0, 1'b0, 32'h0,       4'd1, 32'h70,      1'b0, 1'b0);
        add(1'b0, 1'b1, 32'hA0,      1'b0, 1'b0, 1'b0, 32'h0,       4'd2, 32'hA0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 32'hB0,      1'b1, 1'b0, 1'b0, 32'h0,       4'd2, 32'hB0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'hA0,      4'd2, 32'hB0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd1, 32'h70,      1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'hB0,      4'd1, 32'h70,      1'b0, 1'b0);
        // return-and-call on empty: underflow, then push
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b0);
        add(1'b0, 1'b1, 32'hC0,      1'b1, 1'b0, 1'b0, 32'h0,       4'd1, 32'hC0,      1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,       4'd1, 32'hC0,      1'b0, 1'b0);
        // flush with a pending resolve suppresses the compare
        add(1'b0, 1'b1, 32'h50,      1'b0, 1'b0, 1'b0, 32'h0,       4'd2, 32'h50,      1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd1, 32'hC0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 32'h99,      4'd0, 32'h0,       1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h99,      4'd0, 32'h0,       1'b0, 1'b0);
        // reset while loaded, reset beats a pop
        add(1'b0, 1'b1, 32'h11,      1'b0, 1'b0, 1'b0, 32'h0,       4'd1, 32'h11,      1'b0, 1'b0);
        add(1'b0, 1'b1, 32'h22,      1'b0, 1'b0, 1'b0, 32'h0,       4'd2, 32'h22,      1'b0, 1'b0);
        add(1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0,       4'd0, 32'h0,       1'b0, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check_vec(vecs[i], i);
        end

        // Hand-written: reset lands on the edge where a resolve is pending.
        hv = '{rst:1'b0, push:1'b1, paddr:32'h33, pop:1'b0, flush:1'b0, res:1'b0,
               rtgt:32'h0, e_cnt:4'd1, e_top:32'h33, e_mis:1'b0, e_und:1'b0};
        apply(hv); check_vec(hv, 100);
        hv.push = 1'b0; hv.pop = 1'b1; hv.e_cnt = 4'd0; hv.e_top = 32'h0;
        apply(hv); check_vec(hv, 101);
        hv.pop = 1'b0; hv.rst = 1'b1; hv.res = 1'b1; hv.rtgt = 32'h99;
        apply(hv); check_vec(hv, 102);
        hv.rst = 1'b0;
        apply(hv); check_vec(hv, 103);
        hv.res = 1'b0; hv.push = 1'b1; hv.paddr = 32'hDD; hv.e_cnt = 4'd1; hv.e_top = 32'hDD;
        apply(hv); check_vec(hv, 104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
